// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - HD44780 command constants, init ROM and state types for the score writer
//   No ports; imported by lcd_byte_xfer and lcd_score_writer.
package lcd_pkg;

    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;
    localparam logic [7:0] DISP_ON       = 8'h0C;
    localparam logic [7:0] CLEAR         = 8'h01;
    localparam logic [7:0] ENTRY_INC     = 8'h06;
    localparam logic [7:0] DDRAM_L2      = 8'hC0;

    localparam int INIT_LEN = 6;

    // Function set is repeated three times so the controller syncs to 8-bit mode
    // regardless of the interface state it powered up in.
    localparam logic [7:0] INIT_ROM [0:INIT_LEN-1] = '{
        FUNC_SET_8B2L, FUNC_SET_8B2L, FUNC_SET_8B2L, DISP_ON, CLEAR, ENTRY_INC
    };

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT,
        ST_IDLE,
        ST_ADDR,
        ST_CH0,
        ST_CH1,
        ST_CH2
    } lcd_state_t;

    typedef enum logic [1:0] {
        XF_IDLE,
        XF_SETUP,
        XF_PULSE,
        XF_HOLD
    } xfer_phase_t;

endpackage

// File: rtl/lcd_byte_xfer.sv
// rtl/lcd_byte_xfer.sv - one LCD byte write: SETUP, enable PULSE, then HOLD wait
//   clk_in, i_rst      : clock, synchronous active-high reset
//   i_start            : accepted only while idle; latches i_byte/i_rs/i_long_wait
//   i_long_wait        : use CLEAR_WAIT_CYC instead of CMD_WAIT_CYC for HOLD
//   o_done             : 1-cycle pulse in the last HOLD clock
//   o_lcd_data/o_lcd_rs: held from start of SETUP until the next transfer starts
//   o_lcd_en           : high for E_PULSE_CYC clocks
module lcd_byte_xfer
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = 4,
    parameter int E_PULSE_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000
) (
    input  logic       clk_in,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_byte,
    input  logic       i_rs,
    input  logic       i_long_wait,
    output logic       o_done,
    output logic [7:0] o_lcd_data,
    output logic       o_lcd_rs,
    output logic       o_lcd_en
);

    localparam int MAX_A   = (SETUP_CYC > E_PULSE_CYC) ? SETUP_CYC : E_PULSE_CYC;
    localparam int MAX_B   = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC : CLEAR_WAIT_CYC;
    localparam int MAX_CYC = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(MAX_CYC + 1);

    xfer_phase_t   r_phase;
    xfer_phase_t   w_phase_nxt;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_data;
    logic          r_rs;
    logic          r_long;
    logic          w_cnt_zero;

    assign w_cnt_zero = (r_cnt == '0);

    always_ff @(posedge clk_in) begin
        if (i_rst) begin
            r_phase <= XF_IDLE;
        end else begin
            r_phase <= w_phase_nxt;
        end
    end

    always_comb begin
        w_phase_nxt = r_phase;
        case (r_phase)
            XF_IDLE:  if (i_start)   w_phase_nxt = XF_SETUP;
            XF_SETUP: if (w_cnt_zero) w_phase_nxt = XF_PULSE;
            XF_PULSE: if (w_cnt_zero) w_phase_nxt = XF_HOLD;
            XF_HOLD:  if (w_cnt_zero) w_phase_nxt = XF_IDLE;
            default:  w_phase_nxt = XF_IDLE;
        endcase
    end

    // Each phase loads (length - 1) so a phase lasts exactly its parameter in clocks.
    always_ff @(posedge clk_in) begin
        if (i_rst) begin
            r_cnt  <= '0;
            r_data <= '0;
            r_rs   <= 1'b0;
            r_long <= 1'b0;
        end else begin
            case (r_phase)
                XF_IDLE: begin
                    if (i_start) begin
                        r_cnt  <= CW'(SETUP_CYC - 1);
                        r_data <= i_byte;
                        r_rs   <= i_rs;
                        r_long <= i_long_wait;
                    end
                end
                XF_SETUP: r_cnt <= w_cnt_zero ? CW'(E_PULSE_CYC - 1) : r_cnt - CW'(1);
                XF_PULSE: begin
                    if (w_cnt_zero) begin
                        r_cnt <= r_long ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                XF_HOLD: if (!w_cnt_zero) r_cnt <= r_cnt - CW'(1);
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_done     = (r_phase == XF_HOLD) && w_cnt_zero;
    assign o_lcd_en   = (r_phase == XF_PULSE);
    assign o_lcd_data = r_data;
    assign o_lcd_rs   = r_rs;

endmodule

// File: rtl/lcd_score_writer.sv
// rtl/lcd_score_writer.sv - LCD init sequencer and 3-character score writer
//   clk_in, i_rst : clock, synchronous active-high reset
//   score_in      : ASCII score, [23:16] drawn first
//   score_req     : rising edge requests a redraw (one-deep, latest wins)
//   ready         : init sequence complete
//   busy          : low only when idle with nothing pending
//   lcd_data, lcd_rs, lcd_rw, lcd_en, lcd_on : LCD pins
module lcd_score_writer
    import lcd_pkg::*;
#(
    parameter int POWERUP_CYC    = 750000,
    parameter int SETUP_CYC      = 4,
    parameter int E_PULSE_CYC    = 25,
    parameter int CMD_WAIT_CYC   = 2500,
    parameter int CLEAR_WAIT_CYC = 100000,
    parameter int SCORE_COL      = 7
) (
    input  logic        clk_in,
    input  logic        i_rst,
    input  logic [23:0] score_in,
    input  logic        score_req,
    output logic        ready,
    output logic        busy,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_rw,
    output logic        lcd_en,
    output logic        lcd_on
);

    localparam int         PW       = $clog2(POWERUP_CYC + 1);
    localparam logic [7:0] ADDR_CMD = DDRAM_L2 + 8'(SCORE_COL);

    lcd_state_t    r_state;
    lcd_state_t    w_state_nxt;
    logic [PW-1:0] r_pwr_cnt;
    logic [2:0]    r_init_idx;
    logic          r_req_d;
    logic          r_pending;
    logic          r_ready;
    logic          r_in_flight;
    logic [23:0]   r_pend_score;
    logic [23:0]   r_act_score;

    logic          w_req_edge;
    logic          w_start;
    logic          w_done;
    logic [7:0]    w_byte;
    logic          w_rs;
    logic          w_long_wait;
    logic          w_init_last;
    logic          w_consume;

    assign w_req_edge  = score_req & ~r_req_d;
    assign w_long_wait = !w_rs && (w_byte == CLEAR);
    assign w_init_last = (r_state == ST_INIT) && w_done && (r_init_idx == 3'(INIT_LEN - 1));
    assign w_consume   = (r_state == ST_IDLE) && r_pending;

    always_ff @(posedge clk_in) begin
        if (i_rst) begin
            r_state <= ST_PWRUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sending states issue start once per byte; r_in_flight blocks re-issue until done.
    always_comb begin
        w_state_nxt = r_state;
        w_byte      = '0;
        w_rs        = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            ST_PWRUP: if (r_pwr_cnt == '0) w_state_nxt = ST_INIT;
            ST_INIT: begin
                w_byte  = INIT_ROM[r_init_idx];
                w_start = !r_in_flight;
                if (w_init_last) w_state_nxt = ST_IDLE;
            end
            ST_IDLE: if (r_pending) w_state_nxt = ST_ADDR;
            ST_ADDR: begin
                w_byte  = ADDR_CMD;
                w_start = !r_in_flight;
                if (w_done) w_state_nxt = ST_CH0;
            end
            ST_CH0: begin
                w_byte  = r_act_score[23:16];
                w_rs    = 1'b1;
                w_start = !r_in_flight;
                if (w_done) w_state_nxt = ST_CH1;
            end
            ST_CH1: begin
                w_byte  = r_act_score[15:8];
                w_rs    = 1'b1;
                w_start = !r_in_flight;
                if (w_done) w_state_nxt = ST_CH2;
            end
            ST_CH2: begin
                w_byte  = r_act_score[7:0];
                w_rs    = 1'b1;
                w_start = !r_in_flight;
                if (w_done) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_PWRUP;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (i_rst) begin
            r_pwr_cnt    <= PW'(POWERUP_CYC - 1);
            r_init_idx   <= '0;
            r_req_d      <= 1'b0;
            r_pending    <= 1'b0;
            r_ready      <= 1'b0;
            r_in_flight  <= 1'b0;
            r_pend_score <= '0;
            r_act_score  <= '0;
        end else begin
            r_req_d <= score_req;

            if ((r_state == ST_PWRUP) && (r_pwr_cnt != '0)) begin
                r_pwr_cnt <= r_pwr_cnt - PW'(1);
            end

            if (w_start) begin
                r_in_flight <= 1'b1;
            end else if (w_done) begin
                r_in_flight <= 1'b0;
            end

            if ((r_state == ST_INIT) && w_done) begin
                r_init_idx <= w_init_last ? 3'd0 : r_init_idx + 3'd1;
            end

            if (w_init_last) begin
                r_ready <= 1'b1;
            end

            // End of init forces a redraw of whatever score_in holds now; an edge in
            // the same cycle as consumption re-arms pending so that update is not lost.
            if (w_req_edge || w_init_last) begin
                r_pend_score <= score_in;
                r_pending    <= 1'b1;
            end else if (w_consume) begin
                r_pending    <= 1'b0;
            end

            if (w_consume) begin
                r_act_score <= r_pend_score;
            end
        end
    end

    lcd_byte_xfer #(
        .SETUP_CYC      (SETUP_CYC),
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC)
    ) u_xfer (
        .clk_in      (clk_in),
        .i_rst       (i_rst),
        .i_start     (w_start),
        .i_byte      (w_byte),
        .i_rs        (w_rs),
        .i_long_wait (w_long_wait),
        .o_done      (w_done),
        .o_lcd_data  (lcd_data),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_en    (lcd_en)
    );

    assign ready  = r_ready;
    assign busy   = !((r_state == ST_IDLE) && !r_pending);
    assign lcd_rw = 1'b0;
    assign lcd_on = 1'b1;

endmodule

// File: tb/tb_lcd_score_writer.sv
// tb/tb_lcd_score_writer.sv - self-checking bench for lcd_score_writer
module tb_lcd_score_writer;

    localparam int POWERUP_CYC    = 20;
    localparam int SETUP_CYC      = 2;
    localparam int E_PULSE_CYC    = 3;
    localparam int CMD_WAIT_CYC   = 5;
    localparam int CLEAR_WAIT_CYC = 12;
    localparam int SCORE_COL      = 7;

    logic        clk_in    = 1'b0;
    logic        i_rst     = 1'b1;
    logic [23:0] score_in  = 24'h0;
    logic        score_req = 1'b0;
    logic        ready;
    logic        busy;
    logic [7:0]  lcd_data;
    logic        lcd_rs;
    logic        lcd_rw;
    logic        lcd_en;
    logic        lcd_on;

    always #5 clk_in = ~clk_in;

    lcd_score_writer #(
        .POWERUP_CYC    (POWERUP_CYC),
        .SETUP_CYC      (SETUP_CYC),
        .E_PULSE_CYC    (E_PULSE_CYC),
        .CMD_WAIT_CYC   (CMD_WAIT_CYC),
        .CLEAR_WAIT_CYC (CLEAR_WAIT_CYC),
        .SCORE_COL      (SCORE_COL)
    ) dut (
        .clk_in    (clk_in),
        .i_rst     (i_rst),
        .score_in  (score_in),
        .score_req (score_req),
        .ready     (ready),
        .busy      (busy),
        .lcd_data  (lcd_data),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_on    (lcd_on)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Captured LCD writes and expected writes, each entry {rs, data}.
    logic [8:0] cap_q[$];
    logic [8:0] exp_q[$];

    // Reset as the DUT saw it at the last rising edge.
    logic rst_q = 1'b1;
    initial forever begin
        @(posedge clk_in);
        rst_q = i_rst;
    end

    // Bus monitor: records each write at lcd_en rise and checks pulse width,
    // setup stability and that data holds through the post-pulse wait.
    logic [7:0] m_prev_data = 8'h0;
    logic       m_prev_rs   = 1'b0;
    logic       m_prev_en   = 1'b0;
    logic       m_last_clear = 1'b0;
    int         m_high   = 0;
    int         m_low    = 1000;
    int         m_stable = 1;
    int         m_wait   = 0;

    initial forever begin
        @(negedge clk_in);
        if (rst_q) begin
            m_high       = 0;
            m_low        = 1000;
            m_stable     = 1;
            m_wait       = 0;
            m_last_clear = 1'b0;
        end else begin
            if (lcd_en) m_high++;
            else if (m_prev_en) m_low = 1;
            else m_low++;

            if ((lcd_data !== m_prev_data) || (lcd_rs !== m_prev_rs)) begin
                check("data_hold", (!lcd_en && (m_low > m_wait)), 1);
                m_stable = 1;
            end else begin
                m_stable++;
            end

            if (lcd_en && !m_prev_en) begin
                check("setup_stable", (m_stable >= SETUP_CYC + 1), 1);
                check("rw_low", lcd_rw, 0);
                if (m_last_clear) begin
                    check("clear_gap", ((m_low >= CLEAR_WAIT_CYC + SETUP_CYC) &&
                                        (m_low <= CLEAR_WAIT_CYC + SETUP_CYC + 1)), 1);
                end
                cap_q.push_back({lcd_rs, lcd_data});
                m_last_clear = (!lcd_rs && (lcd_data == 8'h01));
                m_wait       = m_last_clear ? CLEAR_WAIT_CYC : CMD_WAIT_CYC;
                m_high       = 1;
            end

            if (!lcd_en && m_prev_en) begin
                check("en_width", m_high, E_PULSE_CYC);
            end
        end
        m_prev_en   = lcd_en;
        m_prev_data = lcd_data;
        m_prev_rs   = lcd_rs;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic expect_init();
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h38});
        exp_q.push_back({1'b0, 8'h0C});
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h06});
    endtask

    task automatic expect_write(input logic [23:0] s);
        logic [7:0] addr;
        addr = 8'hC0 + 8'(SCORE_COL);
        exp_q.push_back({1'b0, addr});
        exp_q.push_back({1'b1, s[23:16]});
        exp_q.push_back({1'b1, s[15:8]});
        exp_q.push_back({1'b1, s[7:0]});
    endtask

    task automatic send_req(input logic [23:0] s, input int hold);
        score_in  = s;
        score_req = 1'b1;
        tick(hold);
        score_req = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input string tag);
        int t;
        t = 0;
        while ((busy !== 1'b0) && (t < 5000)) begin
            @(negedge clk_in);
            t++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    task automatic wait_caps(input string tag, input int n);
        int t;
        t = 0;
        while ((cap_q.size() < n) && (t < 1000)) begin
            @(negedge clk_in);
            t++;
        end
        check({tag, "_caps"}, (cap_q.size() >= n), 1);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, cap_q.size(), exp_q.size());
        for (int i = 0; (i < exp_q.size()) && (i < cap_q.size()); i++) begin
            check($sformatf("%s_b%0d", tag, i), cap_q[i], exp_q[i]);
        end
        cap_q.delete();
        exp_q.delete();
    endtask

    function automatic logic [23:0] rand_score();
        logic [7:0] a;
        logic [7:0] b;
        a = 8'h30 + 8'($urandom_range(0, 9));
        b = 8'h30 + 8'($urandom_range(0, 9));
        return {a, 8'h2C, b};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] s;
        logic [23:0] last;
        int          nb;
        int          t;

        // Reset values
        score_in = 24'h302C30;
        tick(3);
        check("rst_ready", ready, 0);
        check("rst_busy", busy, 1);
        check("rst_data", lcd_data, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_rw", lcd_rw, 0);
        check("rst_en", lcd_en, 0);
        check("rst_on", lcd_on, 1);
        i_rst = 1'b0;

        // Init sequence then initial score draw
        tick(5);
        check("pwrup_ready", ready, 0);
        check("pwrup_en", lcd_en, 0);
        expect_init();
        expect_write(24'h302C30);
        wait_idle("init");
        check("init_ready", ready, 1);
        compare_stream("init");

        // Held request from idle: exactly one write
        send_req(24'h302C31, 3);
        expect_write(24'h302C31);
        wait_idle("held");
        tick(20);
        compare_stream("held");

        // Two requests during CH0: current write unchanged, one follow-up with latest
        send_req(24'h302C31, 1);
        expect_write(24'h302C31);
        wait_caps("burst", 2);
        send_req(24'h312C31, 1);
        send_req(24'h322C31, 1);
        expect_write(24'h322C31);
        wait_idle("burst");
        compare_stream("burst");

        // Randomized idle requests with optional bursts during the write
        for (int it = 0; it < 8; it++) begin
            s  = rand_score();
            nb = $urandom_range(0, 2);
            send_req(s, $urandom_range(1, 3));
            expect_write(s);
            if (nb > 0) begin
                wait_caps($sformatf("rnd%0d", it), 2);
                last = s;
                for (int j = 0; j < nb; j++) begin
                    last = rand_score();
                    send_req(last, $urandom_range(1, 2));
                end
                expect_write(last);
            end
            wait_idle($sformatf("rnd%0d", it));
            tick($urandom_range(0, 5));
            compare_stream($sformatf("rnd%0d", it));
        end

        // Reset during CH1 pulse, with a request during power-up
        send_req(24'h312C32, 1);
        wait_caps("abort", 3);
        check("abort_en_hi", lcd_en, 1);
        i_rst = 1'b1;
        tick(1);
        check("abort_en", lcd_en, 0);
        check("abort_ready", ready, 0);
        check("abort_busy", busy, 1);
        i_rst = 1'b0;
        cap_q.delete();
        score_in = 24'h332C30;
        tick(3);
        send_req(24'h332C30, 1);
        t = 5;
        while (!lcd_en && (t < 200)) begin
            @(negedge clk_in);
            t++;
        end
        check("replay_delay", ((t >= POWERUP_CYC + SETUP_CYC) && (t <= POWERUP_CYC + SETUP_CYC + 3)), 1);
        expect_init();
        expect_write(24'h332C30);
        wait_idle("replay");
        tick(20);
        check("replay_ready", ready, 1);
        compare_stream("replay");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
